// File: rtl/tx_frame_sender_if.sv
// Command/response and UART byte handshake bundle for tx_frame_sender.
// Names keep the i_/o_ prefixes as seen from the sender itself.
interface tx_frame_sender_if;
  logic        i_Send;
  logic [7:0]  i_Cmd;
  logic [7:0]  i_Status;
  logic [31:0] i_Data;
  logic        i_Tx_Busy;
  logic        i_Tx_Done;
  logic [7:0]  o_Tx_Data;
  logic        o_Tx_Start;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Error;

  // Controller + UART side.
  modport master (
    output i_Send, i_Cmd, i_Status, i_Data, i_Tx_Busy, i_Tx_Done,
    input  o_Tx_Data, o_Tx_Start, o_Busy, o_Done, o_Error
  );

  // Frame sender side.
  modport slave (
    input  i_Send, i_Cmd, i_Status, i_Data, i_Tx_Busy, i_Tx_Done,
    output o_Tx_Data, o_Tx_Start, o_Busy, o_Done, o_Error
  );
endinterface

// File: rtl/tx_frame_sender.sv
// Sends {SYNC, Cmd, Status, Data[31:0], CHK} as eight UART byte transactions
// and reports frame completion or a per-byte transmit timeout.
module tx_frame_sender #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         GAP_CYCLES = 0,
  parameter int         TX_TIMEOUT = 1_000_000
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  tx_frame_sender_if.slave bus,
  output logic [2:0]       o_debug_state
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  localparam logic [2:0] FIN       = 3'd5;

  localparam int TW = $clog2(TX_TIMEOUT) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TX_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]    state;
  logic [2:0]    idx;
  logic [7:0]    cmdQ;
  logic [7:0]    statusQ;
  logic [31:0]   dataQ;
  logic [7:0]    txData;
  logic          txStart;
  logic          error;
  logic [TW-1:0] toCnt;
  logic [GW-1:0] gapCnt;
  logic [7:0]    chk;
  logic [7:0]    frameByte;

  // Checksum covers everything except the sync byte, modulo 256.
  always_comb begin
    chk = cmdQ + statusQ + dataQ[31:24] + dataQ[23:16] + dataQ[15:8] + dataQ[7:0];
    frameByte = SYNC_BYTE;
    case (idx)
      3'd0:    frameByte = SYNC_BYTE;
      3'd1:    frameByte = cmdQ;
      3'd2:    frameByte = statusQ;
      3'd3:    frameByte = dataQ[31:24];
      3'd4:    frameByte = dataQ[23:16];
      3'd5:    frameByte = dataQ[15:8];
      3'd6:    frameByte = dataQ[7:0];
      default: frameByte = chk;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state   <= IDLE;
      idx     <= '0;
      cmdQ    <= '0;
      statusQ <= '0;
      dataQ   <= '0;
      txData  <= '0;
      txStart <= 1'b0;
      error   <= 1'b0;
      toCnt   <= '0;
      gapCnt  <= '0;
    end else begin
      txStart <= 1'b0;
      error   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_Send) begin
            cmdQ    <= bus.i_Cmd;
            statusQ <= bus.i_Status;
            dataQ   <= bus.i_Data;
            state   <= LOAD;
          end
        end
        LOAD: begin
          txData <= frameByte;
          state  <= START;
        end
        START: begin
          if (!bus.i_Tx_Busy) begin
            txStart <= 1'b1;
            toCnt   <= '0;
            state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A done arriving on the expiry cycle still counts as success.
          if (bus.i_Tx_Done) begin
            if (idx == 3'd7) begin
              state <= FIN;
            end else begin
              idx    <= idx + 3'd1;
              gapCnt <= '0;
              state  <= (GAP_CYCLES == 0) ? LOAD : GAP;
            end
          end else if (toCnt == TO_LAST) begin
            error <= 1'b1;
            idx   <= '0;
            state <= IDLE;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        GAP: begin
          if (gapCnt == GAP_LAST) state <= LOAD;
          else                    gapCnt <= gapCnt + 1'b1;
        end
        FIN: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Busy and Done are pure state decodes, so Busy drops the cycle after FIN.
  assign bus.o_Tx_Data  = txData;
  assign bus.o_Tx_Start = txStart;
  assign bus.o_Busy     = (state != IDLE);
  assign bus.o_Done     = (state == FIN);
  assign bus.o_Error    = error;
  assign o_debug_state  = state;

endmodule

// File: tb/tb_tx_frame_sender.sv
// Bench for tx_frame_sender: two instances (no gap / 4-cycle gap) driven by a
// cycle-level UART model, with a frame-level byte scoreboard per instance.
module tb_tx_frame_sender;

  localparam logic [7:0] SYNC     = 8'hA5;
  localparam int         TO       = 100;
  localparam int         GAP_STEP = 4;

  logic i_Clock = 1'b0;
  logic i_Reset;
  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  logic        send     [2];
  logic [7:0]  cmd      [2];
  logic [7:0]  status   [2];
  logic [31:0] data     [2];
  logic        uBusy    [2];
  logic        holdBusy [2];
  logic        txDone   [2];
  logic [7:0]  txData   [2];
  logic        txStart  [2];
  logic        busyO    [2];
  logic        doneO    [2];
  logic        errO     [2];
  logic [2:0]  dbg      [2];

  int   doneDelay [2];
  bit   noDone    [2];
  int   nStart    [2];
  int   nDone     [2];
  int   nErr      [2];
  int   lastStart [2];
  int   lastDone  [2];
  logic [7:0] expQ [2][$];

  int nCheck = 0;
  int nFail  = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCheck++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #2;
  endtask

  // Reference frame: sync, cmd, status, data MSB first, then 8-bit sum of bytes 1..6.
  task automatic pushFrame(input int g, input logic [7:0] c, input logic [7:0] s,
                           input logic [31:0] d);
    logic [7:0] b [8];
    logic [7:0] sum;
    b[0] = SYNC;
    b[1] = c;
    b[2] = s;
    for (int k = 0; k < 4; k++) b[3+k] = d[31-8*k -: 8];
    sum = 8'h00;
    for (int k = 1; k < 7; k++) sum = sum + b[k];
    b[7] = sum;
    for (int k = 0; k < 8; k++) expQ[g].push_back(b[k]);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gDut
    tx_frame_sender_if bus ();

    assign bus.i_Send      = send[g];
    assign bus.i_Cmd       = cmd[g];
    assign bus.i_Status    = status[g];
    assign bus.i_Data      = data[g];
    assign bus.i_Tx_Busy   = uBusy[g] | holdBusy[g];
    assign bus.i_Tx_Done   = txDone[g];
    assign txData[g]       = bus.o_Tx_Data;
    assign txStart[g]      = bus.o_Tx_Start;
    assign busyO[g]        = bus.o_Busy;
    assign doneO[g]        = bus.o_Done;
    assign errO[g]         = bus.o_Error;

    tx_frame_sender #(
      .SYNC_BYTE (SYNC),
      .GAP_CYCLES(g * GAP_STEP),
      .TX_TIMEOUT(TO)
    ) dut (
      .i_Clock      (i_Clock),
      .i_Reset      (i_Reset),
      .bus          (bus.slave),
      .o_debug_state(dbg[g])
    );

    // UART model plus scoreboard/monitor for this instance.
    initial begin
      int cnt;
      bit prevDone;
      cnt = 0;
      prevDone = 1'b0;
      uBusy[g] = 1'b0;
      txDone[g] = 1'b0;
      lastStart[g] = 0;
      lastDone[g] = 0;
      forever begin
        @(posedge i_Clock);
        #1;
        if (i_Reset) begin
          uBusy[g] = 1'b0;
          txDone[g] = 1'b0;
          cnt = 0;
          prevDone = 1'b0;
        end else begin
          txDone[g] = 1'b0;
          if (txStart[g]) begin
            nStart[g]++;
            checkEq("start_expected", expQ[g].size() != 0, 1);
            if (expQ[g].size() != 0) begin
              if (expQ[g].size() < 8)
                checkEq("done_to_start", cyc - lastDone[g] - 1, g * GAP_STEP + 2);
              checkEq("tx_byte", txData[g], expQ[g].pop_front());
            end
            lastStart[g] = cyc;
            uBusy[g] = 1'b1;
            cnt = doneDelay[g];
          end else if (uBusy[g]) begin
            cnt--;
            if (cnt <= 0) begin
              uBusy[g] = 1'b0;
              if (!noDone[g]) begin
                txDone[g] = 1'b1;
                lastDone[g] = cyc;
              end
            end
          end
          if (doneO[g]) begin
            nDone[g]++;
            checkEq("done_err_excl", errO[g], 0);
            checkEq("busy_during_fin", busyO[g], 1);
          end
          if (errO[g]) begin
            nErr[g]++;
            checkEq("timeout_latency", cyc - lastStart[g], TO);
          end
          if (prevDone) checkEq("busy_after_done", busyO[g], 0);
          prevDone = doneO[g];
        end
      end
    end
  end

  task automatic sendFrame(input int g, input logic [7:0] c, input logic [7:0] s,
                           input logic [31:0] d, input bit lat);
    pushFrame(g, c, s, d);
    cmd[g] = c;
    status[g] = s;
    data[g] = d;
    send[g] = 1'b1;
    tick();
    send[g] = 1'b0;
    if (lat) begin
      checkEq("lat_busy", busyO[g], 1);
      checkEq("lat_load", dbg[g], 1);
      tick();
      checkEq("lat_state_start", dbg[g], 2);
      tick();
      checkEq("lat_tx_start", txStart[g], 1);
    end
  endtask

  task automatic waitEnd(input int g, input int budget, output bit sawD, output bit sawE);
    sawD = 1'b0;
    sawE = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (doneO[g]) begin sawD = 1'b1; break; end
      if (errO[g])  begin sawE = 1'b1; break; end
    end
    checkEq("frame_end_in_budget", sawD | sawE, 1);
  endtask

  task automatic runFrame(input int g, input logic [7:0] c, input logic [7:0] s,
                          input logic [31:0] d, input bit lat);
    int s0, e0, d0;
    bit sawD, sawE;
    s0 = nStart[g];
    e0 = nErr[g];
    d0 = nDone[g];
    sendFrame(g, c, s, d, lat);
    waitEnd(g, 3000, sawD, sawE);
    checkEq("frame_done", sawD, 1);
    checkEq("frame_starts", nStart[g] - s0, 8);
    checkEq("frame_done_count", nDone[g] - d0, 1);
    checkEq("frame_no_err", nErr[g] - e0, 0);
    checkEq("frame_bytes_left", expQ[g].size(), 0);
    tick();
    checkEq("idle_after_fin", dbg[g], 0);
  endtask

  initial begin
    int s0, d0, e0, guard;
    bit sawD, sawE;
    i_Reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      send[g] = 1'b0; cmd[g] = '0; status[g] = '0; data[g] = '0;
      holdBusy[g] = 1'b0; noDone[g] = 1'b0; doneDelay[g] = 10;
    end
    repeat (3) tick();
    i_Reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      checkEq("rst_state", dbg[g], 0);
      checkEq("rst_tx_data", txData[g], 0);
      checkEq("rst_tx_start", txStart[g], 0);
      checkEq("rst_busy", busyO[g], 0);
      checkEq("rst_done", doneO[g], 0);
      checkEq("rst_error", errO[g], 0);
    end

    // Directed frames: reference values and checksum wrap.
    runFrame(0, 8'h01, 8'h00, 32'h32001A05, 1'b1);
    runFrame(0, 8'hFF, 8'hFF, 32'hFFFFFFFF, 1'b1);

    // Random frames with random UART completion times.
    for (int n = 0; n < 4; n++) begin
      doneDelay[0] = $urandom_range(1, 12);
      runFrame(0, 8'($urandom), 8'($urandom), $urandom, 1'b1);
    end
    doneDelay[0] = 10;

    // UART held busy: no start until it frees; mid-frame sends are ignored.
    s0 = nStart[0];
    d0 = nDone[0];
    holdBusy[0] = 1'b1;
    sendFrame(0, 8'($urandom), 8'($urandom), $urandom, 1'b0);
    for (int i = 0; i < 50; i++) begin
      send[0] = (i == 7) || (i == 29);
      cmd[0] = 8'($urandom);
      status[0] = 8'($urandom);
      data[0] = $urandom;
      tick();
    end
    send[0] = 1'b0;
    checkEq("gate_no_start", nStart[0] - s0, 0);
    checkEq("gate_state", dbg[0], 2);
    holdBusy[0] = 1'b0;
    tick();
    checkEq("gate_first_free_start", txStart[0], 1);
    for (int i = 0; i < 40; i++) begin
      send[0] = ($urandom_range(0, 7) == 0);
      cmd[0] = 8'($urandom);
      tick();
    end
    send[0] = 1'b0;
    waitEnd(0, 3000, sawD, sawE);
    checkEq("gate_frame_done", sawD, 1);
    checkEq("gate_starts", nStart[0] - s0, 8);
    checkEq("gate_done_count", nDone[0] - d0, 1);
    checkEq("gate_bytes_left", expQ[0].size(), 0);
    tick();

    // Timeout: UART never signals done.
    d0 = nDone[0];
    e0 = nErr[0];
    noDone[0] = 1'b1;
    sendFrame(0, 8'($urandom), 8'($urandom), $urandom, 1'b1);
    waitEnd(0, 3000, sawD, sawE);
    checkEq("to_error", sawE, 1);
    checkEq("to_no_done", nDone[0] - d0, 0);
    checkEq("to_err_count", nErr[0] - e0, 1);
    checkEq("to_state_idle", dbg[0], 0);
    checkEq("to_bytes_left", expQ[0].size(), 7);
    expQ[0].delete();
    noDone[0] = 1'b0;
    tick();
    runFrame(0, 8'($urandom), 8'($urandom), $urandom, 1'b1);

    // Done arriving one cycle after expiry is too late.
    e0 = nErr[0];
    doneDelay[0] = TO;
    sendFrame(0, 8'($urandom), 8'($urandom), $urandom, 1'b1);
    waitEnd(0, 3000, sawD, sawE);
    checkEq("late_done_error", sawE, 1);
    checkEq("late_done_err_count", nErr[0] - e0, 1);
    expQ[0].delete();
    repeat (3) tick();
    checkEq("late_done_ignored", dbg[0], 0);
    doneDelay[0] = 10;

    // Reset right after the byte-3 start.
    s0 = nStart[0];
    d0 = nDone[0];
    e0 = nErr[0];
    sendFrame(0, 8'($urandom), 8'($urandom), $urandom, 1'b1);
    guard = 0;
    while ((nStart[0] - s0 < 4) && (guard < 3000)) begin
      tick();
      guard++;
    end
    checkEq("rst_mid_reached_byte3", nStart[0] - s0, 4);
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    checkEq("rst_mid_state", dbg[0], 0);
    checkEq("rst_mid_tx_start", txStart[0], 0);
    checkEq("rst_mid_tx_data", txData[0], 0);
    checkEq("rst_mid_busy", busyO[0], 0);
    checkEq("rst_mid_done", doneO[0], 0);
    checkEq("rst_mid_error", errO[0], 0);
    checkEq("rst_mid_bytes_left", expQ[0].size(), 4);
    expQ[0].delete();
    repeat (20) tick();
    checkEq("rst_mid_no_done", nDone[0] - d0, 0);
    checkEq("rst_mid_no_err", nErr[0] - e0, 0);
    runFrame(0, 8'($urandom), 8'($urandom), $urandom, 1'b1);

    // Gapped instance, including done coincident with timeout expiry.
    for (int n = 0; n < 3; n++) begin
      doneDelay[1] = $urandom_range(1, 12);
      runFrame(1, 8'($urandom), 8'($urandom), $urandom, 1'b1);
    end
    doneDelay[1] = TO - 1;
    runFrame(1, 8'($urandom), 8'($urandom), $urandom, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nCheck, nFail);
    $finish;
  end

endmodule
